// File: rtl/dmem_arb_if.sv
// Bus bundle for dmem_arb: CPU port, host port and the shared memory port.
// The arbiter connects through the slave modport. The master modport is the
// requester/memory side.
interface dmem_arb_if;
  // CPU port
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;

  // Host port
  logic        host_req;
  logic        host_we;
  logic        host_lock;
  logic [15:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [15:0] host_rdata;

  // Memory port (mem_rdata is valid one cycle after mem_addr)
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arb.sv
// dmem_arb: two-port (CPU / host) arbiter for a single-ported data memory.
// The CPU normally has priority. The host is forced through after waiting
// MAX_WAIT cycles. Grants are combinational and read data returns one cycle
// later, qualified by the owning port's rvalid.
// Optional feature: define DMEM_ARB_LOCK_EN to enable host locked bursts of up
// to LOCK_MAX consecutive grants.
module dmem_arb #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned LOCK_MAX = 8
) (
  input logic        clk,
  input logic        rst_n,
  dmem_arb_if.slave  bus
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
  localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {NORM, FORCE, LOCK} state_t;
`else
  typedef enum logic [0:0] {NORM, FORCE} state_t;
`endif

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_t;

  state_t     state;
  owner_t     rd_owner;
  logic [3:0] wait_cnt;
  logic [3:0] wait_nxt;
  logic       host_pri;
  logic       cpu_gnt_c;
  logic       host_gnt_c;

`ifdef DMEM_ARB_LOCK_EN
  logic [3:0] lock_cnt;
  logic       relock_hold;
`else
  logic       unused_lock;
  assign unused_lock = ^{bus.host_lock, LOCK_LIM};
`endif

  // Host priority: always in FORCE, and in LOCK while the host keeps its lock
  always_comb begin
    host_pri = (state == FORCE);
`ifdef DMEM_ARB_LOCK_EN
    if (state == LOCK && bus.host_lock)
      host_pri = 1'b1;
`endif
  end

  // Combinational grants. Both are forced low while reset is asserted.
  always_comb begin
    cpu_gnt_c  = rst_n && bus.cpu_req && !(host_pri && bus.host_req);
    host_gnt_c = rst_n && bus.host_req && !cpu_gnt_c;
  end

  assign bus.cpu_gnt   = cpu_gnt_c;
  assign bus.host_gnt  = host_gnt_c;
  assign bus.cpu_stall = bus.cpu_req && !cpu_gnt_c;

  // Memory port driven by the granted requester, zero when idle
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    if (cpu_gnt_c) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_we    = bus.cpu_we;
    end else if (host_gnt_c) begin
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
      bus.mem_we    = bus.host_we;
    end
  end

  // Read data is shared. Only the owning port's rvalid qualifies it.
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.host_rdata = bus.mem_rdata;

  // rvalid is the registered read owner. It is also masked by rst_n so that a
  // read pending when reset is applied never shows up as a valid beat.
  assign bus.cpu_rvalid  = rst_n && (rd_owner == OWN_CPU);
  assign bus.host_rvalid = rst_n && (rd_owner == OWN_HOST);

  // Next host wait count: saturating, cleared on host grant or no request
  always_comb begin
    if (!bus.host_req || host_gnt_c)
      wait_nxt = '0;
    else if (wait_cnt >= WAIT_LIM)
      wait_nxt = WAIT_LIM;
    else
      wait_nxt = wait_cnt + 4'd1;
  end

  // Arbitration FSM, wait/lock counters and read-owner tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= NORM;
      wait_cnt    <= '0;
      rd_owner    <= OWN_NONE;
`ifdef DMEM_ARB_LOCK_EN
      lock_cnt    <= '0;
      relock_hold <= 1'b0;
`endif
    end else begin
      wait_cnt <= wait_nxt;

      if (cpu_gnt_c && !bus.cpu_we)
        rd_owner <= OWN_CPU;
      else if (host_gnt_c && !bus.host_we)
        rd_owner <= OWN_HOST;
      else
        rd_owner <= OWN_NONE;

`ifdef DMEM_ARB_LOCK_EN
      relock_hold <= 1'b0;
`endif

      case (state)
`ifdef DMEM_ARB_LOCK_EN
        LOCK: begin
          if (host_gnt_c && bus.host_lock) begin
            if (lock_cnt + 4'd1 >= LOCK_LIM) begin
              // Burst exhausted: give the CPU at least one cycle before relocking
              state       <= NORM;
              lock_cnt    <= '0;
              relock_hold <= 1'b1;
            end else begin
              lock_cnt <= lock_cnt + 4'd1;
            end
          end else begin
            state    <= NORM;
            lock_cnt <= '0;
          end
        end
`endif
        default: begin
`ifdef DMEM_ARB_LOCK_EN
          if (host_gnt_c && bus.host_lock && !relock_hold) begin
            // The entering grant is the first locked grant of the burst
            if (LOCK_LIM <= 4'd1) begin
              state       <= NORM;
              lock_cnt    <= '0;
              relock_hold <= 1'b1;
            end else begin
              state    <= LOCK;
              lock_cnt <= 4'd1;
            end
          end else
`endif
          if (state == FORCE) begin
            if (host_gnt_c || !bus.host_req)
              state <= NORM;
          end else if (bus.host_req && !host_gnt_c && wait_nxt == WAIT_LIM) begin
            state <= FORCE;
          end
        end
      endcase
    end
  end

endmodule
